// File: rtl/demux_pkg.sv
// Shared constants for the 4-way 32-bit router slice.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_CH0 = 2'b00,
    SEL_CH1 = 2'b01,
    SEL_CH2 = 2'b10,
    SEL_CH3 = 2'b11
  } sel_e;

endpackage

// File: rtl/demux_slot32.sv
// One-entry holding slot: a write always wins and leaves the slot full.
module demux_slot32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // A read of an empty slot is harmless; data is held after a read, not cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4way32_buf.sv
// Registered 1-to-4 router: select decode and in_ready mux over four holding slots.
module demux4way32_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic              busy,
  output logic              drop_err
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] rd;
  logic [WIDTH-1:0]  data [NUM_CH];
  logic              transfer;

  // Only the selected slot gates the producer, keeping words in order.
  always_comb begin
    in_ready = !reset && (!full[in_sel] || out_ready[in_sel]);
    transfer = in_valid && in_ready;
    wr       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      wr[k] = transfer && (in_sel == SEL_W'(k));
    end
    rd = full & out_ready;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot32 #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[k]),
      .wr_data (in_data),
      .rd      (rd[k]),
      .full    (full[k]),
      .data    (data[k])
    );
  end

  assign out_valid = full;
  assign busy      = |full;
  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];

`ifdef SYNTHESIS
  assign drop_err = 1'b0;
`else
  // Simulation-only trap for an undriven select while a word is offered.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_err <= 1'b0;
    end else if (in_valid && $isunknown(in_sel)) begin
      drop_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux4way32_buf.sv
// Scoreboard bench for demux4way32_buf: per-channel expected-word queues.
module tb_demux4way32_buf;
  import demux_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic        busy;
  logic        drop_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] sb [4][$];
  logic [31:0] mdata [4];
  logic [3:0]  mfull;

  always #5 clk = ~clk;

  demux4way32_buf #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  function automatic logic [31:0] dut_data(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  // Drive one cycle, score outputs against the queues, advance the model.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [31:0] d, input logic [3:0] ordy);
    logic exp_rdy;
    reset = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    #1;
    exp_rdy = !r && (!mfull[s] || ordy[s]);
    tests++;
    if (in_ready !== exp_rdy) begin
      fails++;
      $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
    end
    tests++;
    if (out_valid !== mfull || busy !== (|mfull)) begin
      fails++;
      $display("FAIL out_valid/busy: got %b/%b expected %b/%b", out_valid, busy, mfull, |mfull);
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_d;
      exp_d = mfull[k] ? sb[k][0] : mdata[k];
      tests++;
      if (dut_data(k) !== exp_d) begin
        fails++;
        $display("FAIL out_data%0d: got %h expected %h", k, dut_data(k), exp_d);
      end
    end
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        sb[k].delete();
        mdata[k] = '0;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (mfull[k] && ordy[k]) void'(sb[k].pop_front());
      if (v && exp_rdy) begin
        sb[s].push_back(d);
        mdata[s] = d;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) mfull[k] = (sb[k].size() != 0);
  endtask

  task automatic idle(input logic [3:0] ordy);
    step(1'b0, 1'b0, 2'b00, 32'h0, ordy);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, SEL_CH1, 32'hFFFF_FFFF, 4'b0000);
    step(1'b1, 1'b1, SEL_CH2, 32'h1234_5678, 4'b0000);
    tests++;
    if (out_valid !== 4'b0000 || drop_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: out_valid %b drop_err %b expected 0000/0", out_valid, drop_err);
    end
  endtask

  task automatic test_single_route;
    step(1'b0, 1'b1, SEL_CH2, 32'hDEAD_BEEF, 4'b0000);
    repeat (5) idle(4'b0000);
    tests++;
    if (out_valid !== 4'b0100 || out_data2 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_hold: got %b/%h expected 0100/deadbeef", out_valid, out_data2);
    end
    idle(4'b0100);
    tests++;
    if (out_valid !== 4'b0000) begin
      fails++;
      $display("FAIL single_drain: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_blocking;
    step(1'b0, 1'b1, SEL_CH1, 32'h1111_1111, 4'b0000);
    repeat (4) step(1'b0, 1'b1, SEL_CH1, 32'h2222_2222, 4'b0000);
    tests++;
    if (out_data1 !== 32'h1111_1111) begin
      fails++;
      $display("FAIL block_hold: got %h expected 11111111", out_data1);
    end
    step(1'b0, 1'b1, SEL_CH1, 32'h2222_2222, 4'b0010);
    tests++;
    if (out_valid[1] !== 1'b1 || out_data1 !== 32'h2222_2222) begin
      fails++;
      $display("FAIL block_replace: got %b/%h expected 1/22222222", out_valid[1], out_data1);
    end
    idle(4'b0010);
  endtask

  task automatic test_streaming;
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, SEL_CH3, 32'(i), 4'b1000);
    idle(4'b1000);
    tests++;
    if (out_valid !== 4'b0000 || out_data3 !== 32'h8) begin
      fails++;
      $display("FAIL stream_end: got %b/%h expected 0000/00000008", out_valid, out_data3);
    end
  endtask

  task automatic test_fanout;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'(k), 32'hA0 + 32'(k), 4'b0000);
    tests++;
    if (out_valid !== 4'b1111 || busy !== 1'b1) begin
      fails++;
      $display("FAIL fanout_full: got %b/%b expected 1111/1", out_valid, busy);
    end
    idle(4'b1111);
    tests++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fanout_drain: got %b/%b expected 0000/0", out_valid, busy);
    end
  endtask

  task automatic test_mid_reset;
    step(1'b0, 1'b1, SEL_CH0, 32'hC0C0_C0C0, 4'b0000);
    step(1'b0, 1'b1, SEL_CH2, 32'hC2C2_C2C2, 4'b0000);
    step(1'b1, 1'b0, SEL_CH0, 32'h0, 4'b0000);
    tests++;
    if (out_valid !== 4'b0000 || out_data0 !== 32'h0 || out_data2 !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: got %b/%h/%h expected 0000/0/0", out_valid, out_data0, out_data2);
    end
    repeat (2) idle(4'b1111);
  endtask

  initial begin
    mfull = '0;
    for (int k = 0; k < 4; k++) mdata[k] = '0;
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_route();
    test_blocking();
    test_streaming();
    test_fanout();
    test_mid_reset();
    tests++;
    if ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 || drop_err !== 1'b0) begin
      fails++;
      $display("FAIL final_state: pending %0d drop_err %b expected 0/0",
               sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), drop_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
